// File: rtl/wb_flush_ctrl_if.sv
// wb_flush_ctrl_if
//   Bundles every signal between the ALU output mux, the writeback/redirect
//   stage and the register file / PC register into one interface.
//
//   Upstream side (driven by the mux / pipeline control):
//     stall        hold the stage
//     valid_in     instruction present this cycle
//     alu_mux_out  ALU result or branch target
//     wb_en_in     conditional-execute-qualified writeback enable
//     noop_in      taken branch, alu_mux_out is the target
//     rd_in        destination register
//   Downstream side (driven by wb_flush_ctrl):
//     rf_we / rf_waddr / rf_wdata        register-file write port
//     pc_load / pc_target                one-cycle PC redirect
//     squash                             upstream instruction is a bubble
//     fwd_valid / fwd_addr / fwd_data    forwarding of the registered result
//
//   modport slave  : the view of wb_flush_ctrl itself
//   modport master : the view of whoever drives the stage inputs
interface wb_flush_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);

  logic              stall;
  logic              valid_in;
  logic [DATA_W-1:0] alu_mux_out;
  logic              wb_en_in;
  logic              noop_in;
  logic [REG_AW-1:0] rd_in;

  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic              squash;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;

  modport slave (
    input  stall,
    input  valid_in,
    input  alu_mux_out,
    input  wb_en_in,
    input  noop_in,
    input  rd_in,
    output rf_we,
    output rf_waddr,
    output rf_wdata,
    output pc_load,
    output pc_target,
    output squash,
    output fwd_valid,
    output fwd_addr,
    output fwd_data
  );

  modport master (
    output stall,
    output valid_in,
    output alu_mux_out,
    output wb_en_in,
    output noop_in,
    output rd_in,
    input  rf_we,
    input  rf_waddr,
    input  rf_wdata,
    input  pc_load,
    input  pc_target,
    input  squash,
    input  fwd_valid,
    input  fwd_addr,
    input  fwd_data
  );

endinterface

// File: rtl/wb_flush_ctrl.sv
// wb_flush_ctrl
//   Writeback and branch-redirect stage. Commits ALU results to the register
//   file, turns taken branches and writes to r15 into a one-cycle PC load,
//   squashes the younger in-flight instructions for FLUSH_DEPTH non-stalled
//   cycles after a redirect, and forwards the registered result for one cycle.
//
//   Parameters:
//     DATA_W       datapath width
//     REG_AW       register address width
//     FLUSH_DEPTH  cycles squashed after a redirect (1..7)
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, synchronous release
//     bus    wb_flush_ctrl_if.slave, see the interface file for signals
//
//   All outputs are registered, with one cycle of latency from the accepted
//   input.
module wb_flush_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_flush_ctrl_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // r15 lives in the PC register, so writing it is a redirect, not an RF write
  localparam logic [REG_AW-1:0] PC_REG     = REG_AW'(15);
  localparam logic [2:0]        FLUSH_INIT = 3'(FLUSH_DEPTH);

  state_t     state;
  logic [2:0] cnt;

  logic accept;
  logic is_pc_write;
  logic do_redirect;
  logic do_write;

  // Decode of the instruction at the input; only meaningful when accepted
  always_comb begin
    accept      = 1'b0;
    is_pc_write = 1'b0;
    do_redirect = 1'b0;
    do_write    = 1'b0;

    accept      = bus.valid_in && !bus.stall && (state == RUN);
    is_pc_write = bus.wb_en_in && (bus.rd_in == PC_REG);
    do_redirect = accept && (bus.noop_in || is_pc_write);
    // a branch never writes the RF even with wb_en_in set
    do_write    = accept && bus.wb_en_in && !bus.noop_in && !is_pc_write;
  end

  // Stall freezes everything except the strobes, which drop to 0 so a
  // write or redirect is never issued twice. Address/data registers keep
  // their last value when no new result arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      cnt           <= 3'd0;
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= {REG_AW{1'b0}};
      bus.rf_wdata  <= {DATA_W{1'b0}};
      bus.pc_load   <= 1'b0;
      bus.pc_target <= {DATA_W{1'b0}};
      bus.squash    <= 1'b0;
      bus.fwd_valid <= 1'b0;
      bus.fwd_addr  <= {REG_AW{1'b0}};
      bus.fwd_data  <= {DATA_W{1'b0}};
    end else if (bus.stall) begin
      bus.rf_we   <= 1'b0;
      bus.pc_load <= 1'b0;
    end else begin
      bus.rf_we     <= do_write;
      bus.pc_load   <= do_redirect;
      bus.fwd_valid <= do_write;

      if (do_write) begin
        bus.rf_waddr <= bus.rd_in;
        bus.rf_wdata <= bus.alu_mux_out;
        bus.fwd_addr <= bus.rd_in;
        bus.fwd_data <= bus.alu_mux_out;
      end

      if (do_redirect) begin
        bus.pc_target <= bus.alu_mux_out;
      end

      case (state)
        RUN: begin
          if (do_redirect) begin
            state      <= FLUSH;
            cnt        <= FLUSH_INIT;
            bus.squash <= 1'b1;
          end
        end
        FLUSH: begin
          // cnt counts the squash cycles still owed including this one,
          // so leaving on cnt==1 gives exactly FLUSH_DEPTH squashed cycles
          if (cnt <= 3'd1) begin
            state      <= RUN;
            cnt        <= 3'd0;
            bus.squash <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state      <= RUN;
          cnt        <= 3'd0;
          bus.squash <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the outputs
  a_no_dual_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.rf_we && bus.pc_load));

  a_load_starts_squash: assert property (@(posedge clk) disable iff (!rst_n)
    bus.pc_load |-> bus.squash);

  a_no_write_in_squash: assert property (@(posedge clk) disable iff (!rst_n)
    bus.squash |-> !bus.rf_we);

  a_fwd_follows_we: assert property (@(posedge clk) disable iff (!rst_n)
    bus.rf_we |-> bus.fwd_valid);

endmodule
